bt_tx: RTL and testbench
========================

BT_TX -- requirements
Module: bt_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208 (9600 baud at 50 MHz), clock cycles per serial bit, legal range 2..65535.
REQ-002 clk  input  1  system clock; all logic is rising-edge triggered; single clock domain.
REQ-003 reset  input  1  asynchronous, active-low reset; assertion (0) clears all state immediately; release is synchronous to clk.
REQ-004 data_in  input  8  byte to transmit; sampled only on the cycle wr is accepted.
REQ-005 wr  input  1  write strobe; byte accepted when wr=1 and ready=1 at a rising clk edge.
REQ-006 tx  output  1  serial line, idle high; 8N1 framing (8E1 with parity option).
REQ-007 ready  output  1  1 when the one-byte holding register is empty and a write can be accepted.
REQ-008 busy  output  1  1 while a frame (start through stop) is on tx.
REQ-009 done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-010 State machine states SHALL be IDLE, START, DATA, PARITY (option only), STOP.
REQ-011 Baud counter SHALL count 0..CLKS_PER_BIT-1; each state holds tx for exactly CLKS_PER_BIT cycles per bit.
REQ-012 Accepted write in IDLE: byte loads the shift register directly, and the START state with tx=0 begins on the next cycle; ready stays 1.
REQ-013 Accepted write while busy: byte loads the holding register, and ready drops to 0 on the next cycle.
REQ-014 wr while ready=0 SHALL be ignored, with no change to the holding register or the frame in flight.
REQ-015 DATA SHALL shift out bits 0..7, LSB first, with a 3-bit bit index that wraps 7->0 on exit to STOP (or PARITY).
REQ-016 STOP drives tx=1; done=1 on its final cycle.
REQ-017 After STOP with the holding register full, the byte moves to the shift register, START begins on the very next cycle with no idle gap, busy stays 1, and ready returns to 1.
REQ-018 After STOP with the holding register empty, the FSM returns to IDLE; busy=0 and tx=1 on the next cycle.
REQ-019 wr in the same cycle as STOP's final cycle with the holding register empty: the byte is accepted and transmitted back-to-back as in REQ-017.
REQ-020 busy SHALL be combinationally derived from state != IDLE, with no extra latency.
REQ-021 Full-frame latency: accept edge to done pulse = 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).

Reset
REQ-022 While reset=0, outputs SHALL be tx=1, busy=0, ready=1, done=0; state=IDLE; counters, bit index, shift and holding registers = 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame, return tx high immediately (asynchronously), and discard any held byte.
REQ-024 The first write SHALL be accepted on the first rising edge after reset release.

Configuration
REQ-025 Macro BT_TX_PARITY_EN: when defined, the PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-026 Without BT_TX_PARITY_EN: no PARITY state or parity logic; STOP follows DATA bit 7 directly.

Verification (CLKS_PER_BIT=16, 50 MHz clk)
REQ-027 Single byte 0xAA after reset: tx reads 0,0,1,0,1,0,1,0,1,1, each level held 16 cycles; done pulses once at cycle 160 after the accept edge; busy falls the next cycle.
REQ-028 Back-to-back writes 0x55 then 0x0F (second while busy): ready=0 after the second write; the frames are contiguous with no idle cycle; two done pulses 160 cycles apart.
REQ-029 Third write 0xFF while the holding register is full: ignored; only 0x55 and 0x0F appear on tx.
REQ-030 Reset asserted at cycle 70 of a 0xC3 frame: tx=1, busy=0, ready=1 immediately; no done pulse; a new write of 0x3C afterwards transmits correctly.
REQ-031 With BT_TX_PARITY_EN, byte 0x07: the parity bit is 1, the frame is 176 cycles, and done fires at cycle 176.
REQ-032 Loopback into the existing BTr receiver with a matching bit period: bytes 0x00, 0xFF and 0xA5 are received with ready asserted and data_out equal to each byte.

Source files
------------

// File: rtl/bt_tx.sv
// bt_tx: byte-wide serial transmitter, 8N1 framing with a one-byte holding register.
// Define BT_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module bt_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       wr,
  output logic       tx,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  // state  | meaning
  // IDLE   | line idle high, shift register empty
  // START  | start bit (tx=0)
  // DATA   | data bits 0..7, LSB first
  // PARITY | even parity of the data byte (BT_TX_PARITY_EN only)
  // STOP   | stop bit (tx=1), done on its last cycle
`ifdef BT_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_hold;
  logic        r_hold_full;
`ifdef BT_TX_PARITY_EN
  logic        r_par;
`endif

  logic       w_bit_end;
  logic       w_accept;
  logic       w_stop_end;
  logic       w_load;
  logic [7:0] w_load_val;

  assign w_bit_end  = (r_cnt == CNT_LAST);
  assign w_accept   = wr & ~r_hold_full;
  assign w_stop_end = (r_state == S_STOP) & w_bit_end;
  // A byte enters the shift register either straight from an idle write or at the end of a stop bit.
  assign w_load     = ((r_state == S_IDLE) & w_accept) | (w_stop_end & (r_hold_full | w_accept));
  assign w_load_val = (w_stop_end & r_hold_full) ? r_hold : data_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_START;
      S_START: if (w_bit_end) w_next = S_DATA;
      S_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef BT_TX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef BT_TX_PARITY_EN
      S_PARITY: if (w_bit_end) w_next = S_STOP;
`endif
      S_STOP: begin
        if (w_bit_end) w_next = (r_hold_full | w_accept) ? S_START : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx    = 1'b1;
    busy  = (r_state != S_IDLE);
    ready = ~r_hold_full;
    done  = w_stop_end;
    case (r_state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = r_shift[0];
`ifdef BT_TX_PARITY_EN
      S_PARITY: tx = r_par;
`endif
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
`ifdef BT_TX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      if ((r_state == S_IDLE) || w_bit_end) r_cnt <= 16'd0;
      else                                  r_cnt <= r_cnt + 16'd1;

      if ((r_state == S_DATA) && w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_load) begin
        r_shift <= w_load_val;
`ifdef BT_TX_PARITY_EN
        r_par   <= ^w_load_val;
`endif
      end else if ((r_state == S_DATA) && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end

      // The holding register only fills while a frame is in flight and not at its reload point.
      if (w_stop_end && r_hold_full) begin
        r_hold_full <= 1'b0;
        r_hold      <= 8'd0;
      end else if (w_accept && (r_state != S_IDLE) && !w_stop_end) begin
        r_hold_full <= 1'b1;
        r_hold      <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_bt_tx.sv
// tb_bt_tx: randomized and directed checks of bt_tx against a frame-level model and a serial decoder.
module tb_bt_tx;
  localparam int C = 16;
`ifdef BT_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [7:0] DIR_BYTE = 8'h07;
  localparam logic [10:0] EXP_LV = 11'b11000001110;
`else
  localparam int NB = 10;
  localparam logic [7:0] DIR_BYTE = 8'hAA;
  localparam logic [9:0] EXP_LV = 10'b1101010100;
`endif
  localparam int F = NB * C;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       wr = 1'b0;
  logic       tx, ready, busy, done;

  bt_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wr(wr),
    .tx(tx), .ready(ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is NB bit slots of C cycles each.
  bit         m_active = 0;
  bit         m_hold_valid = 0;
  int         m_pos = 0;
  logic [7:0] m_frame = 8'h00;
  logic [7:0] m_hold = 8'h00;
  logic [7:0] exp_q[$];
  int         done_q[$];
  logic [7:0] rx_log[$];

  function automatic logic lvl(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef BT_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_hold_valid = 0; m_pos = 0; m_frame = 8'h00; m_hold = 8'h00;
      exp_q.delete();
    end else begin
      bit acc;
      acc = wr && !m_hold_valid;
      if (!m_active) begin
        if (acc) begin
          m_active = 1; m_pos = 0; m_frame = data_in; exp_q.push_back(data_in);
        end
      end else if (m_pos == F - 1) begin
        if (m_hold_valid) begin
          m_frame = m_hold; m_hold_valid = 0; m_pos = 0; exp_q.push_back(m_hold);
        end else if (acc) begin
          m_frame = data_in; m_pos = 0; exp_q.push_back(data_in);
        end else begin
          m_active = 0;
        end
      end else begin
        m_pos++;
        if (acc) begin
          m_hold = data_in; m_hold_valid = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 1); chk("rst_done", done, 0);
    end else begin
      chk("tx", tx, m_active ? lvl(m_frame, m_pos / C) : 1'b1);
      chk("busy", busy, m_active);
      chk("ready", ready, !m_hold_valid);
      chk("done", done, m_active && (m_pos == F - 1));
      if (done) done_q.push_back(cyc);
    end
  end

  // Serial decoder sampling mid-bit; a reset anywhere in the frame discards it.
  task automatic dwait(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      if (!ab) begin
        @(negedge clk);
        if (!reset) ab = 1;
      end
    end
  endtask

  always begin : decoder
    bit ab;
    logic [7:0] b;
    logic [7:0] e;
    @(negedge clk);
    if (reset && tx == 1'b0) begin
      ab = 0; b = 8'h00;
      dwait(C / 2 - 1, ab);
      if (!ab) chk("rx_start", tx, 0);
      for (int i = 0; i < 8; i++) begin
        dwait(C, ab);
        if (!ab) b[i] = tx;
      end
`ifdef BT_TX_PARITY_EN
      dwait(C, ab);
      if (!ab) chk("rx_parity", tx, ^b);
`endif
      dwait(C, ab);
      if (!ab) begin
        chk("rx_stop", tx, 1);
        rx_log.push_back(b);
        if (exp_q.size() == 0) chk("rx_unexpected", b, 9'h100);
        else begin
          e = exp_q.pop_front();
          chk("rx_byte", b, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    wr = 1'b1; data_in = b;
    tick();
    wr = 1'b0;
  endtask

  function automatic int lat_of(input int idx, input int c0);
    if (done_q.size() > idx) return done_q[idx] - c0 + 1;
    return -1;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int c0, n0, nd, n;
    logic [NB-1:0] lv;
    logic busy_after, ready_after;

    reset = 1'b0;
    repeat (4) tick();
    reset = 1'b1;

    // Single frame, written on the first edge after reset release.
    done_q.delete();
    send(DIR_BYTE);
    c0 = cyc;
    lv = '0; busy_after = 1'b1; ready_after = 1'b0;
    for (int k = 1; k <= F + 10; k++) begin
      if ((k % C) == C / 2 && (k / C) < NB) lv[k / C] = tx;
      if (k == F + 1) begin busy_after = busy; ready_after = ready; end
      tick();
    end
    chk("A_levels", lv, EXP_LV);
    chk("A_done_count", done_q.size(), 1);
    chk("A_done_latency", lat_of(0, c0), F);
    chk("A_busy_after", busy_after, 0);
    chk("A_ready_after", ready_after, 1);

    // Back-to-back with a write ignored while the holding register is full.
    done_q.delete();
    n0 = rx_log.size();
    send(8'h55);
    c0 = cyc;
    repeat (3) tick();
    send(8'h0F);
    chk("B_ready_low", ready, 0);
    repeat (2) tick();
    send(8'hFF);
    repeat (2 * F + 20) tick();
    chk("B_done_count", done_q.size(), 2);
    chk("B_done_latency", lat_of(0, c0), F);
    chk("B_done_spacing", lat_of(1, c0) - lat_of(0, c0), F);
    chk("B_rx_count", rx_log.size() - n0, 2);
    if (rx_log.size() >= n0 + 2) begin
      chk("B_rx_first", rx_log[n0], 8'h55);
      chk("B_rx_second", rx_log[n0 + 1], 8'h0F);
    end

    // Reset mid-frame, then a fresh frame.
    send(8'hC3);
    repeat (69) tick();
    #2 reset = 1'b0;
    #1;
    chk("C_tx_abort", tx, 1);
    chk("C_busy_abort", busy, 0);
    chk("C_ready_abort", ready, 1);
    nd = done_q.size();
    n0 = rx_log.size();
    repeat (20) tick();
    chk("C_no_done", done_q.size(), nd);
    reset = 1'b1;
    send(8'h3C);
    repeat (F + 20) tick();
    chk("C_done_count", done_q.size(), nd + 1);
    chk("C_rx_count", rx_log.size() - n0, 1);
    if (rx_log.size() > n0) chk("C_rx_byte", rx_log[n0], 8'h3C);

    // Write on the final stop cycle with the holding register empty.
    done_q.delete();
    send(8'h81);
    c0 = cyc;
    repeat (F - 1) tick();
    chk("D_done_now", done, 1);
    send(8'h7E);
    repeat (F + 20) tick();
    chk("D_done_count", done_q.size(), 2);
    chk("D_done_spacing", lat_of(1, c0) - lat_of(0, c0), F);

    // Loopback bytes.
    n0 = rx_log.size();
    send(8'h00);
    send(8'hFF);
    n = 0;
    while (!ready && n < 4 * F) begin tick(); n++; end
    chk("E_ready_timeout", ready, 1);
    send(8'hA5);
    repeat (3 * F + 40) tick();
    chk("E_rx_count", rx_log.size() - n0, 3);
    if (rx_log.size() >= n0 + 3) begin
      chk("E_rx_00", rx_log[n0], 8'h00);
      chk("E_rx_ff", rx_log[n0 + 1], 8'hFF);
      chk("E_rx_a5", rx_log[n0 + 2], 8'hA5);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      wr = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        wr = 1'b0;
        #1 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
      end
      tick();
    end
    wr = 1'b0;
    n = 0;
    while ((busy || m_active) && n < 3 * F) begin tick(); n++; end
    chk("R_drain_idle", busy, 0);
    repeat (C) tick();
    chk("R_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
